// File: rtl/cpu_lsu_wb.sv
// cpu_lsu_wb: memory-access / writeback stage of the RV32 pipeline.
// Takes one instruction at a time from execute and runs it over a
// req/gnt/rvalid data bus. Loads are aligned and extended before they
// are written back. ALU results go straight to the register file write port.
// Optional feature macro: LSU_MISALIGN_EXC_EN. When it is defined,
// misaligned half/word accesses are dropped and misalign_exc pulses instead.
module cpu_lsu_wb #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic              ex_wb_en,
  input  logic [2:0]        ex_funct3,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [31:0]       ex_wdata,
  input  logic [4:0]        ex_rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              wr_en,
  output logic [4:0]        rd,
  output logic [31:0]       data_rd,
  output logic              misalign_exc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic              is_store_q, is_store_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [4:0]        rd_lat_q, rd_lat_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [31:0]       mwdata_q, mwdata_d;
  logic              wr_en_q, wr_en_d;
  logic [4:0]        rd_q, rd_d;
  logic [31:0]       data_rd_q, data_rd_d;

  logic              accept;
  logic              is_mem;
  logic              misaligned;
  logic [3:0]        st_be;
  logic [31:0]       st_wdata;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_data;

  assign ex_ready = (state_q == S_IDLE);
  assign accept   = ex_valid && ex_ready;
  assign is_mem   = ex_is_load || ex_is_store;

  // Byte enables and lane-replicated write data for the incoming store
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = ex_wdata;
    case (ex_funct3)
      3'b000: begin
        st_be    = 4'b0001 << ex_addr[1:0];
        st_wdata = {4{ex_wdata[7:0]}};
      end
      3'b001: begin
        st_be    = ex_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{ex_wdata[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_EXC_EN
  logic misalign_q, misalign_d;

  // Detect half/word accesses whose low address bits break natural alignment
  always_comb begin
    misaligned = 1'b0;
    if (ex_is_store) begin
      if (ex_funct3 == 3'b001)      misaligned = ex_addr[0];
      else if (ex_funct3 != 3'b000) misaligned = |ex_addr[1:0];
    end else begin
      if (ex_funct3[1:0] == 2'b01)      misaligned = ex_addr[0];
      else if (ex_funct3[1:0] != 2'b00) misaligned = |ex_addr[1:0];
    end
  end

  assign misalign_exc = misalign_q;
`else
  assign misaligned   = 1'b0;
  assign misalign_exc = 1'b0;
`endif

  // Select and extend the load lane using the funct3/offset captured at accept
  always_comb begin
    case (addr_lo_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'b0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'b0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  // Next-state, transaction capture and writeback generation
  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    funct3_d   = funct3_q;
    addr_lo_d  = addr_lo_q;
    rd_lat_d   = rd_lat_q;
    be_d       = be_q;
    maddr_d    = maddr_q;
    mwdata_d   = mwdata_q;
    wr_en_d    = 1'b0;
    rd_d       = rd_q;
    data_rd_d  = data_rd_q;
`ifdef LSU_MISALIGN_EXC_EN
    misalign_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_mem) begin
            if (misaligned) begin
`ifdef LSU_MISALIGN_EXC_EN
              misalign_d = 1'b1;
`endif
            end else begin
              state_d    = S_REQ;
              is_store_d = ex_is_store;
              funct3_d   = ex_funct3;
              addr_lo_d  = ex_addr[1:0];
              rd_lat_d   = ex_rd;
              be_d       = ex_is_store ? st_be : 4'b1111;
              maddr_d    = {ex_addr[ADDR_W-1:2], 2'b00};
              mwdata_d   = st_wdata;
            end
          end else if (ex_wb_en && (ex_rd != 5'd0)) begin
            wr_en_d   = 1'b1;
            rd_d      = ex_rd;
            data_rd_d = ex_addr;
          end
        end
      end
      S_REQ: begin
        if (mem_gnt) state_d = is_store_q ? S_IDLE : S_RESP;
      end
      S_RESP: begin
        if (mem_rvalid) begin
          state_d = S_IDLE;
          if (rd_lat_q != 5'd0) begin
            wr_en_d   = 1'b1;
            rd_d      = rd_lat_q;
            data_rd_d = ld_data;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and pipeline registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= '0;
      addr_lo_q  <= '0;
      rd_lat_q   <= '0;
      be_q       <= '0;
      maddr_q    <= '0;
      mwdata_q   <= '0;
      wr_en_q    <= 1'b0;
      rd_q       <= '0;
      data_rd_q  <= '0;
`ifdef LSU_MISALIGN_EXC_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      addr_lo_q  <= addr_lo_d;
      rd_lat_q   <= rd_lat_d;
      be_q       <= be_d;
      maddr_q    <= maddr_d;
      mwdata_q   <= mwdata_d;
      wr_en_q    <= wr_en_d;
      rd_q       <= rd_d;
      data_rd_q  <= data_rd_d;
`ifdef LSU_MISALIGN_EXC_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  // Bus signals are driven only while a request is outstanding
  assign mem_req   = (state_q == S_REQ);
  assign mem_we    = mem_req && is_store_q;
  assign mem_be    = mem_req ? be_q : '0;
  assign mem_addr  = mem_req ? maddr_q : '0;
  assign mem_wdata = mem_req ? mwdata_q : '0;

  assign wr_en   = wr_en_q;
  assign rd      = rd_q;
  assign data_rd = data_rd_q;

endmodule

// File: tb/tb_cpu_lsu_wb.sv
// Self-checking bench for cpu_lsu_wb: directed vector table, hand-written
// reset/back-to-back sequences and randomized vectors against a reference model.
module tb_cpu_lsu_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready, ex_is_load, ex_is_store, ex_wb_en;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        wr_en, misalign_exc;
  logic [4:0]  rd;
  logic [31:0] data_rd;

  cpu_lsu_wb #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_load(ex_is_load),
    .ex_is_store(ex_is_store), .ex_wb_en(ex_wb_en), .ex_funct3(ex_funct3),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .wr_en(wr_en), .rd(rd), .data_rd(data_rd),
    .misalign_exc(misalign_exc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld, st, wb;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    logic [4:0]  rdst;
    int          gw, rw;
    logic [31:0] rdata;
    logic        exp_wr;
    logic [31:0] exp_data;
    logic [3:0]  exp_be;
    logic [31:0] exp_maddr, exp_mwdata;
    logic        exp_mis;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  int cyc, wr_cnt, wr_cyc, mis_cnt;
  logic [31:0] wr_data;
  logic [4:0]  wr_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Advance one clock and record writeback/exception activity at the negedge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (wr_en === 1'b1) begin
      wr_cnt++;
      wr_cyc  = cyc;
      wr_data = data_rd;
      wr_rd   = rd;
    end
    if (misalign_exc === 1'b1) mis_cnt++;
  endtask

  task automatic clr_mon();
    cyc = 0; wr_cnt = 0; wr_cyc = -1; mis_cnt = 0; wr_data = '0; wr_rd = '0;
  endtask

  function automatic vec_t mk(logic ld, logic st, logic wb, logic [2:0] f3,
                              logic [31:0] addr, logic [31:0] wdata, logic [4:0] rdst,
                              int gw, int rw, logic [31:0] rdata, logic exp_wr,
                              logic [31:0] exp_data, logic [3:0] exp_be,
                              logic [31:0] exp_maddr, logic [31:0] exp_mwdata,
                              logic exp_mis);
    vec_t v;
    v.ld = ld; v.st = st; v.wb = wb; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.rdst = rdst; v.gw = gw; v.rw = rw; v.rdata = rdata; v.exp_wr = exp_wr;
    v.exp_data = exp_data; v.exp_be = exp_be; v.exp_maddr = exp_maddr;
    v.exp_mwdata = exp_mwdata; v.exp_mis = exp_mis;
    return v;
  endfunction

  // Reference model: access size from funct3, then plain arithmetic on bytes
  function automatic vec_t model(vec_t v);
    vec_t  r = v;
    bit    st = v.st;
    bit    ld = v.ld && !v.st;
    int    size, off, sh;
    logic [31:0] val;
    if (st) size = (v.f3 == 3'd0) ? 1 : (v.f3 == 3'd1) ? 2 : 4;
    else    size = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : 4;
    off = int'(v.addr % 4);
`ifdef LSU_MISALIGN_EXC_EN
    r.exp_mis = (st || ld) && ((v.addr % size) != 0);
`else
    r.exp_mis = 1'b0;
`endif
    r.exp_maddr = v.addr - (v.addr % 4);
    sh = (size == 4) ? 0 : (off - (off % size));
    if (st) begin
      r.exp_be = 4'(((1 << size) - 1) << sh);
      if (size == 1)      r.exp_mwdata = (v.wdata % 256) * 32'h01010101;
      else if (size == 2) r.exp_mwdata = (v.wdata % 65536) * 32'h00010001;
      else                r.exp_mwdata = v.wdata;
    end else begin
      r.exp_be = 4'hF;
      r.exp_mwdata = '0;
    end
    val = v.rdata >> (8 * sh);
    if (size == 1) begin
      val = val % 256;
      if (!v.f3[2] && val >= 128) val = val - 256;
    end else if (size == 2) begin
      val = val % 65536;
      if (!v.f3[2] && val >= 32768) val = val - 65536;
    end
    r.exp_wr   = (v.rdst != 0) && ((ld && !r.exp_mis) || (!st && !ld && v.wb));
    r.exp_data = ld ? val : v.addr;
    return r;
  endfunction

  // Issue one instruction, play the bus side, and compare what the DUT did
  task automatic run_vec(input string nm, input vec_t v);
    bit mem = v.ld || v.st;
    int lat;
    @(negedge clk);
    ex_valid = 1'b1; ex_is_load = v.ld; ex_is_store = v.st; ex_wb_en = v.wb;
    ex_funct3 = v.f3; ex_addr = v.addr; ex_wdata = v.wdata; ex_rd = v.rdst;
    chk({nm, ".ready"}, 32'(ex_ready), 32'd1);
    clr_mon();
    step();
    ex_valid = 1'b0;
    if (mem && v.exp_mis) begin
      chk({nm, ".noreq"}, 32'(mem_req), 32'd0);
    end else if (mem) begin
      for (int g = 0; g <= v.gw; g++) begin
        chk({nm, ".req"}, {25'd0, mem_req, mem_we, mem_be}, {25'd0, 1'b1, v.st, v.exp_be});
        chk({nm, ".maddr"}, mem_addr, v.exp_maddr);
        if (v.st) chk({nm, ".mwdata"}, mem_wdata, v.exp_mwdata);
        mem_gnt = (g == v.gw);
        step();
        mem_gnt = 1'b0;
      end
      if (!v.st) begin
        for (int r = 0; r <= v.rw; r++) begin
          mem_rvalid = (r == v.rw);
          mem_rdata  = (r == v.rw) ? v.rdata : $urandom;
          step();
          mem_rvalid = 1'b0;
        end
      end
    end
    step();
    step();
    chk({nm, ".wrcnt"}, 32'(wr_cnt), 32'(v.exp_wr));
    if (v.exp_wr) begin
      lat = (v.ld && !v.st) ? 3 + v.gw + v.rw : 1;
      chk({nm, ".lat"}, 32'(wr_cyc), 32'(lat));
      chk({nm, ".data"}, wr_data, v.exp_data);
      chk({nm, ".rd"}, 32'(wr_rd), 32'(v.rdst));
    end
    chk({nm, ".mis"}, 32'(mis_cnt), 32'(v.exp_mis));
    chk({nm, ".idle"}, 32'(ex_ready), 32'd1);
  endtask

  vec_t tbl[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Directed table: {ld,st,wb,f3,addr,wdata,rd,gw,rw,rdata, exp_wr,data,be,maddr,mwdata,mis}
    tbl.push_back(mk(0,1,0,3'b000,32'h1003,32'h000000A5,5'd0,3,0,32'h0,   0,32'h0,4'b1000,32'h1000,32'hA5A5A5A5,0));
    tbl.push_back(mk(1,0,0,3'b000,32'h2001,32'h0,5'd5,0,0,32'h00008000,   1,32'hFFFFFF80,4'hF,32'h2000,32'h0,0));
    tbl.push_back(mk(1,0,0,3'b100,32'h2001,32'h0,5'd5,0,0,32'h00008000,   1,32'h00000080,4'hF,32'h2000,32'h0,0));
    tbl.push_back(mk(1,0,0,3'b101,32'h2002,32'h0,5'd4,0,0,32'hBEEF1234,   1,32'h0000BEEF,4'hF,32'h2000,32'h0,0));
    tbl.push_back(mk(1,0,0,3'b010,32'h2004,32'h0,5'd0,0,0,32'hDEADBEEF,   0,32'h0,4'hF,32'h2004,32'h0,0));
    tbl.push_back(mk(0,0,1,3'b000,32'h12345678,32'h0,5'd7,0,0,32'h0,      1,32'h12345678,4'h0,32'h0,32'h0,0));
    tbl.push_back(mk(0,1,0,3'b001,32'h1002,32'h1234ABCD,5'd1,0,0,32'h0,   0,32'h0,4'b1100,32'h1000,32'hABCDABCD,0));
    tbl.push_back(mk(1,0,0,3'b001,32'h2002,32'h0,5'd8,1,2,32'h80010000,   1,32'hFFFF8001,4'hF,32'h2000,32'h0,0));
    tbl.push_back(mk(1,1,1,3'b010,32'h4000,32'h11223344,5'd2,0,0,32'h0,   0,32'h0,4'hF,32'h4000,32'h11223344,0));
    tbl.push_back(mk(0,0,0,3'b000,32'h0BADF00D,32'h0,5'd3,0,0,32'h0,      0,32'h0,4'h0,32'h0,32'h0,0));
`ifdef LSU_MISALIGN_EXC_EN
    tbl.push_back(mk(1,0,0,3'b010,32'h3002,32'h0,5'd9,0,0,32'hCAFEF00D,   0,32'h0,4'hF,32'h3000,32'h0,1));
`else
    tbl.push_back(mk(1,0,0,3'b010,32'h3002,32'h0,5'd9,0,0,32'hCAFEF00D,   1,32'hCAFEF00D,4'hF,32'h3000,32'h0,0));
`endif

    // Reset held with ex_valid=1: everything quiet, ready high
    rst_n = 1'b0; ex_valid = 1'b1; ex_is_load = 1'b0; ex_is_store = 1'b0;
    ex_wb_en = 1'b1; ex_funct3 = '0; ex_addr = 32'h00C0FFEE; ex_wdata = '0;
    ex_rd = 5'd11; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    clr_mon();
    repeat (3) @(negedge clk);
    chk("rst.ready", 32'(ex_ready), 32'd1);
    chk("rst.ctl", {20'd0, mem_req, mem_we, mem_be, wr_en, rd, misalign_exc},
        32'd0);
    chk("rst.maddr", mem_addr, 32'd0);
    chk("rst.mwdata", mem_wdata, 32'd0);
    chk("rst.data_rd", data_rd, 32'd0);
    rst_n = 1'b1;
    step();
    ex_valid = 1'b0;
    chk("rst.first_wr", 32'(wr_en), 32'd1);
    chk("rst.first_data", data_rd, 32'h00C0FFEE);

    foreach (tbl[i]) run_vec($sformatf("tbl%0d", i), tbl[i]);

    // Back-to-back ALU instructions: one writeback per cycle, ready stays high
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      ex_valid = 1'b1; ex_is_load = 1'b0; ex_is_store = 1'b0; ex_wb_en = 1'b1;
      ex_rd = 5'(k + 20); ex_addr = 32'hA000_0000 + 32'(k);
      chk("b2b.ready", 32'(ex_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      chk("b2b.wr", 32'(wr_en), 32'd1);
      chk("b2b.data", data_rd, 32'hA000_0000 + 32'(k));
      chk("b2b.rd", 32'(rd), 32'(k + 20));
    end
    ex_valid = 1'b0;
    step();
    chk("b2b.end", 32'(wr_en), 32'd0);

    // Reset while waiting for rvalid: the late rvalid lands in IDLE and is dropped
    @(negedge clk);
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_is_store = 1'b0; ex_funct3 = 3'b010;
    ex_addr = 32'h5000; ex_rd = 5'd6;
    clr_mon();
    step();
    ex_valid = 1'b0; mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("rresp.busy", 32'(ex_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rresp.async", 32'(ex_ready), 32'd1);
    step();
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h5A5A5A5A;
    step();
    mem_rvalid = 1'b0;
    step();
    step();
    chk("rresp.nowr", 32'(wr_cnt), 32'd0);
    chk("rresp.noreq", 32'(mem_req), 32'd0);

    // Randomized vectors against the reference model
    for (int n = 0; n < 200; n++) begin
      vec_t v;
      int kind = $urandom_range(0, 3);
      v.ld = (kind == 1) || (kind == 3);
      v.st = (kind == 2) || (kind == 3);
      v.wb = 1'($urandom);
      v.f3 = 3'($urandom);
      v.addr = $urandom; v.wdata = $urandom; v.rdata = $urandom;
      v.rdst = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      v.gw = $urandom_range(0, 2); v.rw = $urandom_range(0, 2);
      run_vec($sformatf("rnd%0d", n), model(v));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_lsu_wb.md
Name: cpu_lsu_wb

Overview:
Memory-access and writeback stage of the RV32 pipeline. It sits between the execute stage and the general-purpose register file.
- Accepts one instruction at a time from execute.
- Performs loads and stores over a req/gnt/rvalid data bus.
- Aligns and extends load data.
- Drives the register file write port (wr_en, rd, data_rd).
- Non-memory instructions pass their ALU result straight through to writeback.

Parameters:
- ADDR_W, 32, data bus address width; must be 32.
- RESET_PC_UNUSED, none. The block has no parameters beyond ADDR_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  execute stage presents an instruction
- ex_ready  out  1  block can accept this cycle
- ex_is_load  in  1  instruction is a load
- ex_is_store  in  1  instruction is a store
- ex_wb_en  in  1  non-memory instruction writes rd
- ex_funct3  in  3  RV32 funct3 (access size/sign)
- ex_addr  in  32  load/store address, or ALU result for non-memory instructions
- ex_wdata  in  32  store data (rs2)
- ex_rd  in  5  destination register
- mem_req  out  1  bus request
- mem_we  out  1  1 = write
- mem_be  out  4  byte enables
- mem_addr  out  32  word-aligned address
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data
- wr_en  out  1  register file write enable
- rd  out  5  register file write address
- data_rd  out  32  register file write data
- misalign_exc  out  1  misaligned-access pulse (see Optional Feature)

Behaviour:
- Reset: rst_n is asynchronous, active-low; clk is the clock. Reset forces state IDLE and all outputs to 0, except ex_ready, which is 1 after reset. Reset mid-transaction abandons the access. An mem_rvalid arriving while in IDLE is ignored.
- States:
  - IDLE: ex_ready=1.
  - REQ: mem_req=1; mem_req, mem_we, mem_be, mem_addr and mem_wdata are held stable until mem_gnt.
  - RESP: waiting for mem_rvalid.
- ex_ready = (state==IDLE). An instruction is accepted when ex_valid && ex_ready.
- Accepted load or store: go to REQ next cycle.
  - Store + mem_gnt: go to IDLE; no writeback.
  - Load + mem_gnt: go to RESP.
  - RESP + mem_rvalid: go to IDLE. wr_en pulses the cycle after rvalid, with data_rd holding the aligned data.
- ex_is_load && ex_is_store both 1: treated as a store.
- Accepted non-memory instruction with ex_wb_en=1: wr_en=1 next cycle with data_rd=ex_addr. The block stays in IDLE.
- wr_en is a single-cycle pulse. wr_en is forced to 0 when rd==0.
- mem_addr = {ex_addr[31:2],2'b00}.
- Stores:
  - SB (000): be = 0001 shifted left by addr[1:0]; wdata = byte replicated ×4.
  - SH (001): be = addr[1] ? 1100 : 0011; wdata = halfword replicated ×2.
  - SW (010) and any other funct3: be = 1111.
- Loads (funct3 latched at accept):
  - LB (000) / LBU (100): byte selected by addr[1:0], sign-extended / zero-extended.
  - LH (001) / LHU (101): halfword selected by addr[1], sign-extended / zero-extended.
  - LW (010) and undefined codes: full word.
  - Loads set mem_be = 1111.
- Latency: load accepted at cycle T with mem_gnt at T+1 and mem_rvalid at T+2 gives wr_en at T+3. Each extra wait cycle on gnt or rvalid adds one cycle.

Optional Feature:
- Macro: LSU_MISALIGN_EXC_EN.
- Defined: an LH/LHU/SH with addr[0]=1, or an LW/SW with addr[1:0]≠0, is not issued.
  - mem_req stays 0.
  - misalign_exc pulses 1 for one cycle after accept.
  - No writeback occurs; state stays IDLE.
- Undefined: misalign_exc is tied 0. Misaligned low address bits are ignored per the alignment rules above and the access proceeds.

Test Plan:
- Reset with ex_valid=1 held → all outputs 0, ex_ready=1. Release → first instruction accepted.
- SB, addr=0x1003, wdata=0x000000A5 → mem_be=1000, mem_addr=0x1000, mem_wdata=0xA5A5A5A5; gnt held off 3 cycles → request stable; no wr_en.
- LB, addr=0x2001, rd=5, rdata=0x00008000 → data_rd=0xFFFFFF80, rd=5. LBU, same stimulus → data_rd=0x00000080. Both with wr_en at T+3 under zero-wait gnt/rvalid.
- LHU, addr=0x2002, rdata=0xBEEF1234 → data_rd=0x0000BEEF. LW to rd=0 → wr_en stays 0.
- ALU instruction, ex_addr=0x12345678, rd=7 → wr_en=1, data_rd=0x12345678 next cycle. Back-to-back ALU instructions → one wr_en per cycle, ex_ready stays 1.
- LW, addr=0x3002: with LSU_MISALIGN_EXC_EN → misalign_exc pulse, no mem_req. Without the macro → mem_addr=0x3000, normal load. Assert rst_n in RESP, then rvalid → no wr_en.
